// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, FSM state type and the GF(2^8) xtime helper
// used by the iterative (Inv)MixColumns datapath.
package aes_pkg;

   localparam int STATE_W  = 128;
   localparam int COL_W    = 32;
   localparam int BYTE_W   = 8;
   localparam int NUM_COLS = STATE_W / COL_W;

   // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1 (0x11B).
   localparam logic [BYTE_W-1:0] AES_POLY = 8'h1B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mix_state_e;

   // Multiply by x (02) in GF(2^8).
   function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
      return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? AES_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/inv_mix_column_word.sv
// inv_mix_column_word: combinational AES column core.
//   col_i  [31:0]  input column, [31:24] is row 0
//   fwd_i          (only with AES_MIXCOL_FWD_EN) 1 = forward MixColumns
//   col_o  [31:0]  transformed column, same layout
// Inverse coefficients are built from a single xtime chain per byte
// (x2, x4, x8); the forward path reuses the x2 term.
module inv_mix_column_word
   import aes_pkg::*;
(
   input  logic [COL_W-1:0] col_i,
`ifdef AES_MIXCOL_FWD_EN
   input  logic             fwd_i,
`endif
   output logic [COL_W-1:0] col_o
);

   logic [BYTE_W-1:0] a  [4];
   logic [BYTE_W-1:0] x2 [4];
   logic [BYTE_W-1:0] x4 [4];
   logic [BYTE_W-1:0] x8 [4];
   logic [BYTE_W-1:0] m9 [4];
   logic [BYTE_W-1:0] mb [4];
   logic [BYTE_W-1:0] md [4];
   logic [BYTE_W-1:0] me [4];

   for (genvar g = 0; g < 4; g++) begin : g_byte
      assign a[g]  = col_i[COL_W-1-BYTE_W*g -: BYTE_W];
      assign x2[g] = xtime(a[g]);
      assign x4[g] = xtime(x2[g]);
      assign x8[g] = xtime(x4[g]);
      assign m9[g] = x8[g] ^ a[g];
      assign mb[g] = x8[g] ^ x2[g] ^ a[g];
      assign md[g] = x8[g] ^ x4[g] ^ a[g];
      assign me[g] = x8[g] ^ x4[g] ^ x2[g];
   end

   for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int R1 = (r + 1) % 4;
      localparam int R2 = (r + 2) % 4;
      localparam int R3 = (r + 3) % 4;
      logic [BYTE_W-1:0] inv_b;
      assign inv_b = me[r] ^ mb[R1] ^ md[R2] ^ m9[R3];
`ifdef AES_MIXCOL_FWD_EN
      logic [BYTE_W-1:0] fwd_b;
      // 02*a_r ^ 03*a_r+1 ^ a_r+2 ^ a_r+3, with 03*a = x2 ^ a
      assign fwd_b = x2[r] ^ x2[R1] ^ a[R1] ^ a[R2] ^ a[R3];
      assign col_o[COL_W-1-BYTE_W*r -: BYTE_W] = fwd_i ? fwd_b : inv_b;
`else
      assign col_o[COL_W-1-BYTE_W*r -: BYTE_W] = inv_b;
`endif
   end

endmodule

// File: rtl/inv_mix_columns_iter.sv
// inv_mix_columns_iter: iterative AES InvMixColumns, one column per clock.
//   i_Clk, i_Rst     clock, synchronous active-high reset
//   i_Valid/o_Ready  input handshake, i_Data [127:0] ([127:96] = column 0)
//   o_Valid/i_Ready  output handshake, o_Data [127:0] same layout
//   i_Fwd            only with AES_MIXCOL_FWD_EN: 1 = forward MixColumns,
//                    sampled at accept and held for that state
// Accept -> 4 BUSY cycles (columns 0..3) -> DONE until i_Ready. DONE with
// i_Ready and i_Valid accepts the next state directly.
module inv_mix_columns_iter
   import aes_pkg::*;
(
   input  logic               i_Clk,
   input  logic               i_Rst,
   input  logic               i_Valid,
   output logic               o_Ready,
   input  logic [STATE_W-1:0] i_Data,
   output logic               o_Valid,
   input  logic               i_Ready,
`ifdef AES_MIXCOL_FWD_EN
   input  logic               i_Fwd,
`endif
   output logic [STATE_W-1:0] o_Data
);

   mix_state_e         state_q;
   logic [1:0]         col_cnt_q;
   logic [STATE_W-1:0] work_q;
   logic [STATE_W-1:0] out_q;
   logic [STATE_W-1:0] work_d;
   logic [COL_W-1:0]   col_sel;
   logic [COL_W-1:0]   col_mix;
   logic               accept;
`ifdef AES_MIXCOL_FWD_EN
   logic               fwd_q;
`endif

   always_comb begin
      col_sel = work_q[127:96];
      case (col_cnt_q)
         2'd0: col_sel = work_q[127:96];
         2'd1: col_sel = work_q[95:64];
         2'd2: col_sel = work_q[63:32];
         2'd3: col_sel = work_q[31:0];
         default: col_sel = work_q[127:96];
      endcase
   end

   inv_mix_column_word u_core (
      .col_i (col_sel),
`ifdef AES_MIXCOL_FWD_EN
      .fwd_i (fwd_q),
`endif
      .col_o (col_mix)
   );

   // Write the transformed column back in place.
   always_comb begin
      work_d = work_q;
      case (col_cnt_q)
         2'd0: work_d[127:96] = col_mix;
         2'd1: work_d[95:64]  = col_mix;
         2'd2: work_d[63:32]  = col_mix;
         2'd3: work_d[31:0]   = col_mix;
         default: work_d = work_q;
      endcase
   end

   // Combinational from i_Ready so DONE can hand off and accept in one cycle.
   assign o_Ready = (state_q == IDLE) || ((state_q == DONE) && i_Ready);
   assign accept  = i_Valid && o_Ready;
   assign o_Valid = (state_q == DONE);
   assign o_Data  = out_q;

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q   <= IDLE;
         col_cnt_q <= 2'd0;
         work_q    <= '0;
         out_q     <= '0;
`ifdef AES_MIXCOL_FWD_EN
         fwd_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (accept) begin
                  work_q    <= i_Data;
                  col_cnt_q <= 2'd0;
`ifdef AES_MIXCOL_FWD_EN
                  fwd_q     <= i_Fwd;
`endif
                  state_q   <= BUSY;
               end else if (state_q == DONE && i_Ready) begin
                  state_q <= IDLE;
               end
            end
            BUSY: begin
               work_q    <= work_d;
               col_cnt_q <= col_cnt_q + 2'd1;
               // Output register only moves on the last column so o_Data
               // never shows a partially transformed state.
               if (col_cnt_q == 2'd3) begin
                  out_q   <= work_d;
                  state_q <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
module tb_inv_mix_columns_iter;

   logic         i_Clk = 1'b0;
   logic         i_Rst = 1'b1;
   logic         i_Valid = 1'b0;
   logic         o_Ready;
   logic [127:0] i_Data = '0;
   logic         o_Valid;
   logic         i_Ready = 1'b1;
   logic [127:0] o_Data;
`ifdef AES_MIXCOL_FWD_EN
   logic         i_Fwd = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   inv_mix_columns_iter dut (
      .i_Clk   (i_Clk),
      .i_Rst   (i_Rst),
      .i_Valid (i_Valid),
      .o_Ready (o_Ready),
      .i_Data  (i_Data),
      .o_Valid (o_Valid),
      .i_Ready (i_Ready),
`ifdef AES_MIXCOL_FWD_EN
      .i_Fwd   (i_Fwd),
`endif
      .o_Data  (o_Data)
   );

   always #5 i_Clk = ~i_Clk;

   task automatic step();
      @(posedge i_Clk);
      #1;
   endtask

   // Independent forward MixColumns reference (02/03/01/01).
   function automatic logic [7:0] gm2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] fwd_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a [4];
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) a[r] = s[127-32*c-8*r -: 8];
         for (int r = 0; r < 4; r++)
            o[127-32*c-8*r -: 8] = gm2(a[r]) ^ gm2(a[(r+1)%4]) ^ a[(r+1)%4]
                                   ^ a[(r+2)%4] ^ a[(r+3)%4];
      end
      return o;
   endfunction

   // Present d, accept on the next edge, then wait for o_Valid (bounded).
   task automatic send(input logic [127:0] d, input bit f,
                       output logic [127:0] res, output int lat);
      i_Data  = d;
      i_Valid = 1'b1;
`ifdef AES_MIXCOL_FWD_EN
      i_Fwd   = f;
`else
      if (f) $display("note: fwd request ignored in inverse-only build");
`endif
      step();
      i_Valid = 1'b0;
      i_Data  = {$urandom, $urandom, $urandom, $urandom};
      lat = 0;
      while (!o_Valid && lat < 20) begin
         step();
         lat++;
      end
      res = o_Data;
   endtask

   task automatic test_reset();
      i_Rst = 1'b1;
      step(); step();
      i_Rst = 1'b0;
      total++;
      if (o_Valid !== 1'b0 || o_Ready !== 1'b1 || o_Data !== 128'h0) begin
         bad++;
         $display("FAIL reset: valid=%b ready=%b data=%h, want 0 1 0",
                  o_Valid, o_Ready, o_Data);
      end
   endtask

   task automatic test_vectors();
      logic [127:0] vin  [4];
      logic [127:0] vexp [4];
      logic [127:0] res;
      int lat;
      vin[0]  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
      vexp[0] = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
      vin[1]  = 128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6;
      vexp[1] = 128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5;
      vin[2]  = 128'h4d7ebdf8_00000000_ffffffff_c6c6c6c6;
      vexp[2] = 128'h2d26314c_00000000_ffffffff_c6c6c6c6;
      vin[3]  = 128'h0;
      vexp[3] = 128'h0;
      for (int i = 0; i < 4; i++) begin
         send(vin[i], 1'b0, res, lat);
         total++;
         if (lat !== 4) begin
            bad++;
            $display("FAIL latency[%0d]: got %0d want 4", i, lat);
         end
         total++;
         if (res !== vexp[i]) begin
            bad++;
            $display("FAIL vector[%0d]: got %h want %h", i, res, vexp[i]);
         end
         step(); // i_Ready high: DONE -> IDLE
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] a_res, b_res;
      int lat;
      int bad_hold;
      i_Ready = 1'b0;
      send(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0, a_res, lat);
      total++;
      if (a_res !== 128'hdb135345_f20a225c_01010101_c6c6c6c6) begin
         bad++;
         $display("FAIL bp_first: got %h", a_res);
      end
      // Hold in DONE; a new request waits upstream.
      i_Valid = 1'b1;
      i_Data  = 128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6;
      bad_hold = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (o_Data !== a_res || o_Ready !== 1'b0 || o_Valid !== 1'b1)
            bad_hold++;
      end
      total++;
      if (bad_hold != 0) begin
         bad++;
         $display("FAIL bp_hold: %0d cycles unstable (data=%h ready=%b valid=%b)",
                  bad_hold, o_Data, o_Ready, o_Valid);
      end
      i_Ready = 1'b1;
      #1;
      total++;
      if (o_Ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_ready_comb: got %b want 1", o_Ready);
      end
      step();
      i_Valid = 1'b0;
      total++;
      if (o_Valid !== 1'b0 || o_Data !== a_res) begin
         bad++;
         $display("FAIL b2b_accept: valid=%b data=%h want 0 %h", o_Valid, o_Data, a_res);
      end
      lat = 0;
      while (!o_Valid && lat < 20) begin
         step();
         lat++;
      end
      b_res = o_Data;
      total++;
      if (lat !== 4 || b_res !== 128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5) begin
         bad++;
         $display("FAIL b2b_second: lat=%0d data=%h want 4 d4d4d4d5...", lat, b_res);
      end
      step();
   endtask

   task automatic test_rst_busy();
      int seen;
      i_Data  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
      i_Valid = 1'b1;
      step();          // accepted; first BUSY cycle
      i_Valid = 1'b0;
      step();          // second BUSY cycle
      i_Rst = 1'b1;
      step();
      i_Rst = 1'b0;
      total++;
      if (o_Valid !== 1'b0 || o_Ready !== 1'b1 || o_Data !== 128'h0) begin
         bad++;
         $display("FAIL rst_busy: valid=%b ready=%b data=%h want 0 1 0",
                  o_Valid, o_Ready, o_Data);
      end
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (o_Valid) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL rst_busy_ghost: %0d valid cycles want 0", seen);
      end
      // Reset and valid together: nothing captured.
      i_Data  = 128'h11111111_22222222_33333333_44444444;
      i_Valid = 1'b1;
      i_Rst   = 1'b1;
      step();
      i_Rst   = 1'b0;
      i_Valid = 1'b0;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (o_Valid) seen++;
      end
      total++;
      if (seen != 0 || o_Ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_and_valid: valid_cycles=%0d ready=%b want 0 1", seen, o_Ready);
      end
   endtask

`ifdef AES_MIXCOL_FWD_EN
   task automatic test_fwd();
      logic [127:0] res;
      int lat;
      send(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b1, res, lat);
      total++;
      if (res !== 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6) begin
         bad++;
         $display("FAIL fwd_mix: got %h want 8e4da1bc_9fdc589d...", res);
      end
      step();
      send(res, 1'b0, res, lat);
      total++;
      if (res !== 128'hdb135345_f20a225c_01010101_c6c6c6c6) begin
         bad++;
         $display("FAIL fwd_restore: got %h want db135345_f20a225c...", res);
      end
      step();
   endtask
`endif

   task automatic test_roundtrip();
      logic [127:0] orig, res;
      int lat;
      int errs;
      errs = 0;
      for (int n = 0; n < 300; n++) begin
         orig = {$urandom, $urandom, $urandom, $urandom};
         send(fwd_mix(orig), 1'b0, res, lat);
         if (res !== orig || lat != 4) begin
            errs++;
            if (errs <= 3)
               $display("FAIL roundtrip[%0d]: got %h want %h lat=%0d", n, res, orig, lat);
         end
         step();
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL roundtrip_total: %0d of 300 vectors wrong", errs);
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_back_to_back();
      test_rst_busy();
`ifdef AES_MIXCOL_FWD_EN
      test_fwd();
`endif
      test_roundtrip();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
